// File: rtl/tap_dmi_adapter.sv
// JTAG DTM scan-register block bridging the DTMCS/DMI data registers to a
// valid/ready DMI request/response bus. All state is on the rising edge of TCK_i.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no DMI transaction outstanding, new request may be issued
// ST_REQ     | dmi_req_valid_o high, waiting for dmi_req_ready_i
// ST_WAIT    | dmi_resp_ready_o high, waiting for dmi_resp_valid_i
module tap_dmi_adapter #(
  parameter int unsigned ABITS     = 7,
  parameter int unsigned IDLE_HINT = 1
) (
  input  logic             TCK_i,
  input  logic             TRST_i,
  input  logic             TDI_i,
  input  logic             capture_dr_i,
  input  logic             shift_dr_i,
  input  logic             update_dr_i,
  input  logic             test_logic_reset_i,
  input  logic             sel_dtmcs_i,
  input  logic             sel_dmi_i,
  output logic             tdo_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [31:0]      dmi_req_data_o,
  output logic [1:0]       dmi_req_op_o,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o,
  input  logic [31:0]      dmi_resp_data_i,
  input  logic [1:0]       dmi_resp_op_i
);

  localparam int unsigned DW = ABITS + 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e             state_q;
  logic [1:0]         sticky_q;
  logic [31:0]        dtmcs_q;
  logic [DW-1:0]      dmi_q;
  logic [ABITS-1:0]   last_addr_q;
  logic [31:0]        last_data_q;
  logic               req_valid_q;
  logic               resp_ready_q;
  logic [ABITS-1:0]   req_addr_q;
  logic [31:0]        req_data_q;
  logic [1:0]         req_op_q;

  logic               dtmcs_upd;
  logic               dmi_reset;
  logic               hard_reset;
  logic               dmi_upd;
  logic               dmi_cap;
  logic               op_valid;
  logic               issue;
  logic [31:0]        dtmcs_cap;
  logic [1:0]         dmi_cap_op;

  // Decode of the DTMCS write-side control bits and the DMI issue condition.
  assign dtmcs_upd  = update_dr_i & sel_dtmcs_i;
  assign dmi_reset  = dtmcs_upd & dtmcs_q[16];
  // Test-Logic-Reset behaves as a hard reset of the DMI side as well.
  assign hard_reset = (dtmcs_upd & dtmcs_q[17]) | test_logic_reset_i;
  assign dmi_upd    = update_dr_i & sel_dmi_i;
  assign dmi_cap    = capture_dr_i & sel_dmi_i;
  assign op_valid   = (dmi_q[1:0] == 2'd1) | (dmi_q[1:0] == 2'd2);
  assign issue      = dmi_upd & (state_q == ST_IDLE) & (sticky_q == 2'd0) & op_valid;

  assign dtmcs_cap = {14'b0, 2'b0, 1'b0, 3'(IDLE_HINT), sticky_q, 6'(ABITS), 4'd1};

  // Op reported on a DMI capture: a pending error wins, then busy, else success.
  assign dmi_cap_op = (sticky_q != 2'd0)   ? sticky_q :
                      (state_q != ST_IDLE) ? 2'd3     : 2'd0;

  // Serial output follows the LSB of whichever scan register is selected.
  assign tdo_o = sel_dtmcs_i ? dtmcs_q[0] :
                 sel_dmi_i   ? dmi_q[0]   : 1'b0;

  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_resp_ready_o = resp_ready_q;
  assign dmi_req_addr_o   = req_addr_q;
  assign dmi_req_data_o   = req_data_q;
  assign dmi_req_op_o     = req_op_q;

  // Scan registers: capture, then shift right with TDI entering at the MSB.
  always_ff @(posedge TCK_i or negedge TRST_i) begin
    if (!TRST_i) begin
      dtmcs_q <= '0;
      dmi_q   <= '0;
    end else if (test_logic_reset_i) begin
      dtmcs_q <= '0;
      dmi_q   <= '0;
    end else begin
      if (sel_dtmcs_i) begin
        if (capture_dr_i) begin
          dtmcs_q <= dtmcs_cap;
        end else if (shift_dr_i) begin
          dtmcs_q <= {TDI_i, dtmcs_q[31:1]};
        end
      end
      if (sel_dmi_i) begin
        if (capture_dr_i) begin
          dmi_q <= {last_addr_q, last_data_q, dmi_cap_op};
        end else if (shift_dr_i) begin
          dmi_q <= {TDI_i, dmi_q[DW-1:1]};
        end
      end
    end
  end

  // Transaction FSM with registered bus outputs and the sticky error status.
  always_ff @(posedge TCK_i or negedge TRST_i) begin
    if (!TRST_i) begin
      state_q      <= ST_IDLE;
      sticky_q     <= 2'd0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_op_q     <= '0;
      last_addr_q  <= '0;
      last_data_q  <= '0;
    end else if (hard_reset) begin
      // Abandons any outstanding transaction, even one handshaking this cycle.
      state_q      <= ST_IDLE;
      sticky_q     <= 2'd0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      if (test_logic_reset_i) begin
        last_addr_q <= '0;
        last_data_q <= '0;
      end
    end else begin
      // A sticky error is only ever set from zero, so the first error is kept.
      if (dmi_reset) begin
        sticky_q <= 2'd0;
      end else if ((dmi_cap || dmi_upd) && (state_q != ST_IDLE) && (sticky_q == 2'd0)) begin
        sticky_q <= 2'd3;
      end else if ((state_q == ST_WAIT) && dmi_resp_valid_i &&
                   (sticky_q == 2'd0) && (dmi_resp_op_i != 2'd0)) begin
        sticky_q <= dmi_resp_op_i;
      end

      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            state_q     <= ST_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= dmi_q[DW-1:34];
            req_data_q  <= dmi_q[33:2];
            req_op_q    <= dmi_q[1:0];
            last_addr_q <= dmi_q[DW-1:34];
          end
        end
        ST_REQ: begin
          if (dmi_req_ready_i) begin
            state_q      <= ST_WAIT;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (dmi_resp_valid_i) begin
            state_q      <= ST_IDLE;
            resp_ready_q <= 1'b0;
            last_data_q  <= dmi_resp_data_i;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tap_dmi_adapter.sv
// Directed bench for tap_dmi_adapter (ABITS=7, IDLE_HINT=1).
module tb_tap_dmi_adapter;

  logic        clk = 1'b0;
  logic        trst_n;
  logic        tdi, cap, sh, upd, tlr, sel_dtmcs, sel_dmi;
  logic        tdo;
  logic        req_valid, req_ready;
  logic [6:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_op;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_op;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] dout;

  tap_dmi_adapter #(.ABITS(7), .IDLE_HINT(1)) dut (
    .TCK_i(clk), .TRST_i(trst_n), .TDI_i(tdi),
    .capture_dr_i(cap), .shift_dr_i(sh), .update_dr_i(upd),
    .test_logic_reset_i(tlr), .sel_dtmcs_i(sel_dtmcs), .sel_dmi_i(sel_dmi),
    .tdo_o(tdo),
    .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready),
    .dmi_req_addr_o(req_addr), .dmi_req_data_o(req_data), .dmi_req_op_o(req_op),
    .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready),
    .dmi_resp_data_i(resp_data), .dmi_resp_op_i(resp_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dmi_word(input logic [6:0] a, input logic [31:0] d,
                                           input logic [1:0] o);
    return {23'b0, a, d, o};
  endfunction

  // Full DR scan: capture, shift len bits LSB-first, update. Starts/ends on a negedge.
  task automatic scan(input logic dtm, input logic [63:0] din, input int len,
                      input logic resp_at_upd, output logic [63:0] dq);
    dq = '0;
    sel_dtmcs = dtm;
    sel_dmi   = ~dtm;
    cap = 1'b1;
    @(negedge clk);
    cap = 1'b0;
    sh  = 1'b1;
    for (int i = 0; i < len; i++) begin
      dq[i] = tdo;
      tdi   = din[i];
      @(negedge clk);
    end
    sh  = 1'b0;
    upd = 1'b1;
    if (resp_at_upd) resp_valid = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    if (resp_at_upd) resp_valid = 1'b0;
    sel_dtmcs = 1'b0;
    sel_dmi   = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    trst_n = 1'b0; tdi = 0; cap = 0; sh = 0; upd = 0; tlr = 0;
    sel_dtmcs = 0; sel_dmi = 0; req_ready = 0; resp_valid = 0;
    resp_data = '0; resp_op = '0;
    wait_cycles(2);
    sel_dmi = 1'b1;
    #1;
    chk("rst_tdo", tdo, 0);
    chk("rst_valid", req_valid, 0);
    chk("rst_ready", resp_ready, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_data", req_data, 0);
    chk("rst_op", req_op, 0);
    sel_dmi = 1'b0;
    @(negedge clk);
    trst_n = 1'b1;
    @(negedge clk);

    // DTMCS readout
    scan(1'b1, 64'd0, 32, 1'b0, dout);
    chk("dtmcs_init", dout, 64'h1071);

    // Write with immediate handshake
    req_ready = 1; resp_valid = 1; resp_op = 0; resp_data = 32'hCAFEF00D;
    scan(1'b0, dmi_word(7'h10, 32'hDEADBEEF, 2'd2), 41, 1'b0, dout);
    chk("wr_cap_first", dout, 64'd0);
    chk("wr_valid", req_valid, 1);
    chk("wr_addr", req_addr, 7'h10);
    chk("wr_data", req_data, 32'hDEADBEEF);
    chk("wr_op", req_op, 2);
    @(negedge clk);
    chk("wr_valid_1cyc", req_valid, 0);
    chk("wr_resp_ready", resp_ready, 1);
    @(negedge clk);
    chk("wr_resp_ready_done", resp_ready, 0);

    // Read; capture after write shows op 0 and the write's response data
    resp_data = 32'h12345678;
    scan(1'b0, dmi_word(7'h04, 32'h0, 2'd1), 41, 1'b0, dout);
    chk("rd_prev_cap", dout, dmi_word(7'h10, 32'hCAFEF00D, 2'd0));
    chk("rd_valid", req_valid, 1);
    chk("rd_op", req_op, 1);
    wait_cycles(2);
    scan(1'b0, 64'd0, 41, 1'b0, dout);
    chk("rd_result", dout, dmi_word(7'h04, 32'h12345678, 2'd0));

    // Busy: ready held low
    req_ready = 0; resp_valid = 0;
    scan(1'b0, dmi_word(7'h08, 32'h0, 2'd1), 41, 1'b0, dout);
    wait_cycles(3);
    chk("busy_valid_held", req_valid, 1);
    chk("busy_addr_held", req_addr, 7'h08);
    scan(1'b0, dmi_word(7'h20, 32'h1, 2'd2), 41, 1'b0, dout);
    chk("busy_cap_op", dout[1:0], 3);
    chk("busy_cap_addr", dout[40:34], 7'h08);
    chk("busy_upd_ignored_addr", req_addr, 7'h08);
    chk("busy_upd_ignored_op", req_op, 1);
    scan(1'b1, 64'h10000, 32, 1'b0, dout);
    chk("busy_dmistat3", dout, 64'h1C71);
    scan(1'b1, 64'd0, 32, 1'b0, dout);
    chk("busy_dmireset", dout, 64'h1071);
    req_ready = 1; resp_valid = 1; resp_op = 0; resp_data = 32'h55;
    wait_cycles(3);
    chk("busy_done_valid", req_valid, 0);
    chk("busy_done_ready", resp_ready, 0);

    // Failed response: sticky 2 blocks further requests until dmireset
    resp_op = 2;
    scan(1'b0, dmi_word(7'h30, 32'h1, 2'd2), 41, 1'b0, dout);
    chk("err_prev_cap", dout, dmi_word(7'h08, 32'h55, 2'd0));
    wait_cycles(2);
    scan(1'b0, dmi_word(7'h31, 32'h2, 2'd2), 41, 1'b0, dout);
    chk("err_cap_op", dout[1:0], 2);
    chk("err_upd_ignored", req_valid, 0);
    scan(1'b1, 64'h10000, 32, 1'b0, dout);
    chk("err_dmistat2", dout, 64'h1871);
    resp_op = 0;
    scan(1'b0, dmi_word(7'h32, 32'h3, 2'd2), 41, 1'b0, dout);
    chk("err_cleared_valid", req_valid, 1);
    chk("err_cleared_addr", req_addr, 7'h32);
    wait_cycles(2);

    // TRST in REQ
    req_ready = 0; resp_valid = 0;
    scan(1'b0, dmi_word(7'h40, 32'h0, 2'd1), 41, 1'b0, dout);
    chk("trst_pre_valid", req_valid, 1);
    sel_dmi = 1'b1;
    trst_n = 1'b0;
    #1;
    chk("trst_valid", req_valid, 0);
    chk("trst_addr", req_addr, 0);
    chk("trst_op", req_op, 0);
    chk("trst_tdo", tdo, 0);
    sel_dmi = 1'b0;
    @(negedge clk);
    trst_n = 1'b1;
    @(negedge clk);

    // dmihardreset coincident with resp_valid carrying an error
    req_ready = 1; resp_valid = 0; resp_op = 2; resp_data = 32'h77;
    scan(1'b0, dmi_word(7'h50, 32'h9, 2'd2), 41, 1'b0, dout);
    @(negedge clk);
    chk("hr_in_wait", resp_ready, 1);
    scan(1'b1, 64'h20000, 32, 1'b1, dout);
    chk("hr_resp_ready", resp_ready, 0);
    chk("hr_valid", req_valid, 0);
    resp_op = 0;
    scan(1'b1, 64'd0, 32, 1'b0, dout);
    chk("hr_sticky0", dout, 64'h1071);
    scan(1'b0, 64'd0, 41, 1'b0, dout);
    chk("hr_no_resp_store", dout, dmi_word(7'h50, 32'h0, 2'd0));

    // Test-Logic-Reset clears holding registers
    tlr = 1'b1;
    @(negedge clk);
    tlr = 1'b0;
    scan(1'b0, 64'd0, 41, 1'b0, dout);
    chk("tlr_clear", dout, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
